// File: rtl/button_status_ctrl.sv
// button_status_ctrl: debounce N_CH buttons, latch last accepted press as a display code, sticky error, buzzer drive
// Ports:
//   clk_50MHz    system clock
//   reset        asynchronous active-low reset
//   btn_in       raw button levels, active-high
//   db_level     debounced levels
//   press_pulse  one-cycle pulse on each accepted rising edge
//   status_valid status_code is meaningful
//   status_code  latched channel index
//   error        sticky error flag
//   buzzer       buzzer drive
module button_status_ctrl #(
  parameter int N_CH         = 4,
  parameter int DB_CYCLES    = 1000000,
  parameter int CHIRP_CYCLES = 2500000,
  parameter int BUZZ_HALF    = 12500000,
  parameter int ERR_CH       = 2,
  parameter int CLR_CH       = 1,
  localparam int CODE_W      = $clog2(N_CH)
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic [N_CH-1:0]   btn_in,
  output logic [N_CH-1:0]   db_level,
  output logic [N_CH-1:0]   press_pulse,
  output logic              status_valid,
  output logic [CODE_W-1:0] status_code,
  output logic              error,
  output logic              buzzer
);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int TMAX = CHIRP_CYCLES > BUZZ_HALF ? CHIRP_CYCLES : BUZZ_HALF;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [1:0] IDLE = 2'd0, SHOW = 2'd1, ERROR = 2'd2;
  localparam logic [N_CH-1:0] SPECIAL = (N_CH'(1) << CLR_CH) | (N_CH'(1) << ERR_CH);
  logic [N_CH-1:0] sync1, sync2, db_d, norm;
  logic [DW-1:0] db_cnt [N_CH];
  logic [1:0] state;
  logic [TW-1:0] tmr;
  logic [CODE_W-1:0] low;
  logic p_err, p_clr;
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db_d <= '0;
      db_level <= '0;
      db_cnt <= '{default: '0};
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      db_d <= db_level;
      for (int i = 0; i < N_CH; i++) begin
        if (sync2[i] == db_level[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          db_level[i] <= ~db_level[i];
        end else db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end
  assign press_pulse = db_level & ~db_d;
  assign p_err = press_pulse[ERR_CH];
  assign p_clr = press_pulse[CLR_CH];
  assign norm = press_pulse & ~SPECIAL;
  always_comb begin
    low = '0;
    for (int i = N_CH - 1; i >= 0; i--) low = norm[i] ? CODE_W'(i) : low;
  end
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      status_code <= '0;
      buzzer <= 1'b0;
      tmr <= '0;
    end else if (state == ERROR) begin
      if (p_clr && !p_err) begin
        state <= IDLE;
        status_code <= '0;
        buzzer <= 1'b0;
        tmr <= '0;
      end else if (tmr == TW'(BUZZ_HALF - 1)) begin
        buzzer <= ~buzzer;
        tmr <= '0;
      end else tmr <= tmr + 1'b1;
    end else if (p_err) begin
      state <= ERROR;
      status_code <= CODE_W'(ERR_CH);
      buzzer <= 1'b1;
      tmr <= '0;
    end else if (state == SHOW && p_clr) begin
      state <= IDLE;
      status_code <= '0;
      buzzer <= 1'b0;
      tmr <= '0;
    end else if (|norm) begin
      state <= SHOW;
      status_code <= low;
      buzzer <= 1'b1;
      tmr <= '0;
    end else if (state == SHOW && buzzer) begin
      if (tmr == TW'(CHIRP_CYCLES - 1)) begin
        buzzer <= 1'b0;
        tmr <= '0;
      end else tmr <= tmr + 1'b1;
    end
  end
  assign status_valid = state != IDLE;
  assign error = state == ERROR;
endmodule

// File: tb/tb_button_status_ctrl.sv
// tb_button_status_ctrl: directed checks of debounce, press pulses, status FSM and buzzer timing
module tb_button_status_ctrl;
  logic clk_50MHz = 1'b0;
  logic reset = 1'b0;
  logic [3:0] btn_in = '0;
  logic [3:0] db_level, press_pulse;
  logic status_valid, error, buzzer;
  logic [1:0] status_code;
  logic [4:0] st;
  int tests = 0;
  int fails = 0;
  button_status_ctrl #(
    .N_CH(4), .DB_CYCLES(8), .CHIRP_CYCLES(4), .BUZZ_HALF(16), .ERR_CH(2), .CLR_CH(1)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .reset(reset),
    .btn_in(btn_in),
    .db_level(db_level),
    .press_pulse(press_pulse),
    .status_valid(status_valid),
    .status_code(status_code),
    .error(error),
    .buzzer(buzzer)
  );
  assign st = {status_valid, status_code, error, buzzer};
  always #10 clk_50MHz = ~clk_50MHz;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask
  initial begin
    #1;
    chk("rst_db", db_level, 0);
    chk("rst_pulse", press_pulse, 0);
    chk("rst_st", st, 5'b0_00_0_0);
    step(3);
    reset = 1'b1;
    step(2);
    for (int k = 0; k < 6; k++) begin
      btn_in[0] = ~btn_in[0];
      step(3);
    end
    chk("bounce_db", db_level, 0);
    chk("bounce_st", st, 5'b0_00_0_0);
    btn_in[0] = 1'b1;
    step(9);
    chk("bounce_db9", db_level, 0);
    step(1);
    chk("bounce_db10", db_level, 4'b0001);
    chk("bounce_pulse", press_pulse, 4'b0001);
    chk("bounce_st_pre", st, 5'b0_00_0_0);
    step(1);
    chk("bounce_pulse_end", press_pulse, 0);
    chk("bounce_show", st, 5'b1_00_0_1);
    step(3);
    chk("chirp_4th", st, 5'b1_00_0_1);
    step(1);
    chk("chirp_end", st, 5'b1_00_0_0);
    btn_in[3] = 1'b1;
    step(5);
    btn_in[3] = 1'b0;
    step(12);
    chk("glitch_db", db_level, 4'b0001);
    chk("glitch_st", st, 5'b1_00_0_0);
    btn_in = '0;
    step(12);
    chk("release_db", db_level, 0);
    chk("release_st", st, 5'b1_00_0_0);
    btn_in[0] = 1'b1;
    step(2);
    btn_in[3] = 1'b1;
    step(8);
    chk("stag_pulse0", press_pulse, 4'b0001);
    step(1);
    chk("stag_code0", st, 5'b1_00_0_1);
    step(1);
    chk("stag_pulse3", press_pulse, 4'b1000);
    step(1);
    chk("stag_code3", st, 5'b1_11_0_1);
    step(3);
    chk("restart_hold", st, 5'b1_11_0_1);
    step(1);
    chk("restart_end", st, 5'b1_11_0_0);
    btn_in = '0;
    step(12);
    btn_in = 4'b1001;
    step(10);
    chk("simul03_pulse", press_pulse, 4'b1001);
    step(1);
    chk("simul03_low", st, 5'b1_00_0_1);
    btn_in = '0;
    step(12);
    btn_in[3] = 1'b1;
    step(2);
    btn_in[1] = 1'b1;
    step(8);
    chk("clr_pulse3", press_pulse, 4'b1000);
    step(1);
    chk("clr_show3", st, 5'b1_11_0_1);
    step(1);
    chk("clr_pulse1", press_pulse, 4'b0010);
    step(1);
    chk("clr_idle", st, 5'b0_00_0_0);
    btn_in = '0;
    step(12);
    btn_in = 4'b0010;
    step(11);
    chk("idle_clr_stay", st, 5'b0_00_0_0);
    btn_in = '0;
    step(12);
    btn_in[0] = 1'b1;
    step(11);
    chk("err_pre_show", st, 5'b1_00_0_1);
    btn_in = '0;
    step(12);
    btn_in[2] = 1'b1;
    step(10);
    chk("err_pulse", press_pulse, 4'b0100);
    step(1);
    chk("err_enter", st, 5'b1_10_1_1);
    btn_in[3] = 1'b1;
    step(10);
    chk("err_pulse3", press_pulse, 4'b1000);
    step(1);
    chk("err_ignore3", st, 5'b1_10_1_1);
    step(4);
    chk("buzz_hi_end", st, 5'b1_10_1_1);
    step(1);
    chk("buzz_lo_start", st, 5'b1_10_1_0);
    step(15);
    chk("buzz_lo_end", st, 5'b1_10_1_0);
    step(1);
    chk("buzz_hi_again", st, 5'b1_10_1_1);
    btn_in = 4'b0010;
    step(10);
    chk("err_clr_pulse", press_pulse, 4'b0010);
    step(1);
    chk("err_cleared", st, 5'b0_00_0_0);
    btn_in = '0;
    step(12);
    btn_in[0] = 1'b1;
    step(11);
    chk("sim_pre_show", st, 5'b1_00_0_1);
    btn_in = 4'b0111;
    step(10);
    chk("sim12_pulse", press_pulse, 4'b0110);
    step(1);
    chk("sim12_err", st, 5'b1_10_1_1);
    step(3);
    chk("pre_reset_buzz", st, 5'b1_10_1_1);
    reset = 1'b0;
    #1;
    chk("async_db", db_level, 0);
    chk("async_pulse", press_pulse, 0);
    chk("async_st", st, 5'b0_00_0_0);
    btn_in = 4'b0001;
    step(2);
    reset = 1'b1;
    step(9);
    chk("rel_pulse9", press_pulse, 0);
    step(1);
    chk("rel_pulse10", press_pulse, 4'b0001);
    step(1);
    chk("rel_show", st, 5'b1_00_0_1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
